spi_xfer_sched: RTL
===================

Name: spi_xfer_sched

Overview:
- Scheduler and configurator sitting in front of the byte-wide SPI master register interface (addr/wr/rd/cs/in_data/out_data).
- After reset it programs the master's clock divider once.
- It then shares the master between two requesters using round-robin arbitration, sequencing each transaction as: write byte, poll busy, read received byte.
- It reports completion, received data and a timeout error per transaction.

Parameters:
- CLK_DIV, 8'd4: divider value written to master addr 2'b10 during init.
- POLL_GAP, 4: idle clk cycles between busy polls (0..15).
- TIMEOUT, 255: max busy polls per transaction before abort (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  per-requester transaction request, level; held until done[i].
- req_data  input  16  [7:0] byte for requester 0, [15:8] byte for requester 1.
- done  output  2  one-cycle pulse to the served requester at transaction end.
- rsp_data  output  8  byte read back from the master; valid while done pulses, held after.
- err  output  1  one-cycle pulse with done when the transaction timed out.
- init_done  output  1  high once divider programming completes; stays high until reset.
- m_cs  output  1  master chip-select strobe.
- m_wr  output  1  master write strobe.
- m_rd  output  1  master read strobe.
- m_addr  output  2  master register address.
- m_wdata  output  8  master write data.
- m_rdata  input  8  master read data, combinational from m_addr/m_rd, sampled in the same cycle.

Behaviour:
- Interface and reset:
  - Single clock clk. Reset rst_n is asynchronous, active-low.
  - Reset values: done=0, err=0, rsp_data=0, init_done=0, m_cs=0, m_wr=0, m_rd=0, m_addr=0, m_wdata=0. State is INIT, last-grant pointer is 1 (requester 0 wins first), counters are 0.
- Bus strobes:
  - All m_* outputs are registered.
  - A strobe is always a single cycle with m_cs=1 and exactly one of m_wr/m_rd set.
  - In every other cycle m_cs=m_wr=m_rd=0 and m_addr/m_wdata hold their value.
- States:
  - INIT: drive m_cs=1, m_wr=1, m_addr=2'b10, m_wdata=CLK_DIV for one cycle, then go to IDLE and set init_done=1.
  - IDLE: if req==0, stay. Otherwise grant:
    - If both requesters are active, grant the one not equal to the last-grant pointer.
    - If one is active, grant it.
    - Latch the granted index and its req_data byte, update the pointer, go to WRITE.
    - Grant takes 1 cycle; req changes after the grant do not affect the latched byte.
  - WRITE: strobe m_wr, m_addr=2'b00, m_wdata=latched byte. Clear poll counter and gap counter, go to GAP.
  - GAP: count POLL_GAP cycles, then go to POLL. With POLL_GAP=0, go to POLL the next cycle.
  - POLL: strobe m_rd, m_addr=2'b01. Sample m_rdata[0] in the strobe cycle.
    - If 0 (not busy), go to READ.
    - Otherwise increment the poll counter. If the counter reaches TIMEOUT, go to FINISH with the error flag set; else return to GAP.
  - READ: strobe m_rd, m_addr=2'b00, capture m_rdata into rsp_data, go to FINISH.
  - FINISH: pulse done[granted]=1, and err=1 if timed out. On timeout rsp_data is left unchanged. Go to IDLE.
- Latency with POLL_GAP=g, where busy clears on poll k (k>=1): grant to done = 1 (grant) + 1 (WRITE) + k*(g+1) (GAP/POLL) + 1 (READ) + 1 (FINISH) cycles.
- Boundary cases:
  - A request arriving during INIT is not granted until IDLE.
  - req dropping mid-transaction does not abort it; done still pulses.
  - Both requesters requesting continuously alternate strictly 0,1,0,1.
  - A requester re-requesting in the cycle after its done is eligible at the next IDLE.
  - Reset mid-transaction immediately clears all strobes and outputs and re-runs INIT after release.
- Arithmetic: poll counter is 8 bits, compared with ==TIMEOUT, never wraps. Gap counter is 4 bits.

Test Plan:
- Reset release, CLK_DIV=4 -> exactly one cycle with m_cs=1, m_wr=1, m_addr=2'b10, m_wdata=8'h04; then init_done=1; no further bus activity while req=0.
- req=2'b01, req_data[7:0]=8'hA5, model busy=1 for 2 polls then 0, m_rdata=8'h3C at addr 00, POLL_GAP=4 -> write strobe with 8'hA5; 3 polls each 5 cycles apart; read strobe; done=2'b01, rsp_data=8'h3C, err=0; grant-to-done = 1+1+15+1+1 = 19 cycles.
- req=2'b11 held, bytes 8'h11/8'h22 -> write data sequence 8'h11, 8'h22, 8'h11; done pulses alternate 01, 10, 01.
- Busy stuck at 1, TIMEOUT=3 -> exactly 3 polls, no addr-00 read, done and err pulse together, rsp_data keeps its previous value.
- rst_n asserted during GAP -> all m_* strobes 0 and done=0 asynchronously; after release the INIT write repeats before any transaction.
- req[0] dropped one cycle after grant -> transaction completes and done[0] still pulses once.

Source files
------------

// File: rtl/spi_xfer_sched.sv
// Round-robin transaction scheduler in front of a byte-wide SPI master.
// Programs the clock divider once, then runs write / poll busy / read per request.
module spi_xfer_sched #(
   parameter logic [7:0] CLK_DIV  = 8'd4,
   parameter int         POLL_GAP = 4,
   parameter int         TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   input  logic [15:0] req_data,
   output logic [1:0]  done,
   output logic [7:0]  rsp_data,
   output logic        err,
   output logic        init_done,
   output logic        m_cs,
   output logic        m_wr,
   output logic        m_rd,
   output logic [1:0]  m_addr,
   output logic [7:0]  m_wdata,
   input  logic [7:0]  m_rdata
);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_WRITE, S_GAP, S_POLL, S_READ, S_FINISH
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);
   localparam logic [7:0] TMO      = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        gnt_q, gnt_d;
   logic        gnt_sel;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  poll_q, poll_d;
   logic [3:0]  gap_q, gap_d;
   logic [1:0]  done_q, done_d;
   logic        err_q, err_d;
   logic [7:0]  rsp_q, rsp_d;
   logic        init_q, init_d;
   logic        cs_q, cs_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic [1:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;

   // Bus outputs are registered: each strobe is scheduled on entry to its state.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      gnt_sel = 1'b0;
      byte_d  = byte_q;
      poll_d  = poll_q;
      gap_d   = gap_q;
      done_d  = 2'b00;
      err_d   = 1'b0;
      rsp_d   = rsp_q;
      init_d  = init_q;
      cs_d    = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_INIT: begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = 2'b10;
            wdata_d = CLK_DIV;
            init_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (req != 2'b00) begin
               gnt_sel = (req == 2'b11) ? ~ptr_q : req[1];
               gnt_d   = gnt_sel;
               ptr_d   = gnt_sel;
               byte_d  = gnt_sel ? req_data[15:8] : req_data[7:0];
               cs_d    = 1'b1;
               wr_d    = 1'b1;
               addr_d  = 2'b00;
               wdata_d = byte_d;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            poll_d = 8'd0;
            gap_d  = 4'd0;
            if (POLL_GAP == 0) begin
               cs_d    = 1'b1;
               rd_d    = 1'b1;
               addr_d  = 2'b01;
               state_d = S_POLL;
            end else begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            gap_d = gap_q + 4'd1;
            if (gap_q == GAP_LAST) begin
               cs_d    = 1'b1;
               rd_d    = 1'b1;
               addr_d  = 2'b01;
               state_d = S_POLL;
            end
         end
         S_POLL: begin
            if (!m_rdata[0]) begin
               cs_d    = 1'b1;
               rd_d    = 1'b1;
               addr_d  = 2'b00;
               state_d = S_READ;
            end else begin
               poll_d = poll_q + 8'd1;
               gap_d  = 4'd0;
               if (poll_d == TMO) begin
                  done_d  = gnt_q ? 2'b10 : 2'b01;
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end else if (POLL_GAP == 0) begin
                  cs_d    = 1'b1;
                  rd_d    = 1'b1;
                  addr_d  = 2'b01;
                  state_d = S_POLL;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_READ: begin
            rsp_d   = m_rdata;
            done_d  = gnt_q ? 2'b10 : 2'b01;
            state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         ptr_q   <= 1'b1;
         gnt_q   <= 1'b0;
         byte_q  <= 8'd0;
         poll_q  <= 8'd0;
         gap_q   <= 4'd0;
         done_q  <= 2'b00;
         err_q   <= 1'b0;
         rsp_q   <= 8'd0;
         init_q  <= 1'b0;
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= 2'b00;
         wdata_q <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         byte_q  <= byte_d;
         poll_q  <= poll_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rsp_q   <= rsp_d;
         init_q  <= init_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign done      = done_q;
   assign err       = err_q;
   assign rsp_data  = rsp_q;
   assign init_done = init_q;
   assign m_cs      = cs_q;
   assign m_wr      = wr_q;
   assign m_rd      = rd_q;
   assign m_addr    = addr_q;
   assign m_wdata   = wdata_q;

endmodule
